// File: rtl/dm_pkg.sv
// Shared types for the data-memory responder: FSM states, latched op encoding
// and the word-index width helper.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // OP_BAD marks a request with both MemRead and MemWrite set. Address
  // legality is checked later, against the latched address.
  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_BAD = 2'd2
  } op_t;

  // Bits needed to index DEPTH_WORDS words.
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Request/response bundle between the CPU (master) and the data memory (slave).
interface dm_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic        Req_ready;
  logic        Resp_valid;
  logic        Resp_ready;
  logic [31:0] MemReadData;
  logic        Mem_err;

  modport master (
    output MemRead, MemWrite, MemAddr, MemWriteData, Resp_ready,
    input  Req_ready, Resp_valid, MemReadData, Mem_err
  );

  modport slave (
    input  MemRead, MemWrite, MemAddr, MemWriteData, Resp_ready,
    output Req_ready, Resp_valid, MemReadData, Mem_err
  );
endinterface

// File: rtl/dm_storage.sv
// Word array with one synchronous write port and one combinational read port.
// Contents are deliberately not reset.
module dm_storage #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_word,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Synchronous write.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_word] <= i_wdata;
  end

  assign o_rdata = r_mem[i_word];

endmodule

// File: rtl/dm_responder.sv
// Handshaked data-memory responder: accepts one request at a time, serves it
// from dm_storage after LATENCY cycles, and holds the response until taken.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  dm_responder_if.slave  bus
);

  localparam int unsigned AW = addr_w(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  op_t           r_op;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;

  op_t           w_op_in;
  logic          w_addr_bad;
  logic          w_bad;
  logic          w_fire;
  logic          w_we;
  logic [AW-1:0] w_word;
  logic [31:0]   w_mem_rdata;

  // Classify the incoming op; both strobes together is illegal.
  always_comb begin
    w_op_in = OP_RD;
    if (bus.MemRead && bus.MemWrite) w_op_in = OP_BAD;
    else if (bus.MemWrite)           w_op_in = OP_WR;
  end

  // Misaligned, or any bit set above the array's byte range.
  assign w_addr_bad = (|r_addr[1:0]) | (|r_addr[31:AW+2]);
  assign w_bad      = (r_op == OP_BAD) | w_addr_bad;
  assign w_fire     = (r_state == BUSY) && (r_cnt == '0);
  assign w_we       = w_fire && (r_op == OP_WR) && !w_addr_bad;
  assign w_word     = r_addr[AW+1:2];

  dm_storage #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_storage (
    .clk     (clk),
    .i_we    (w_we),
    .i_word  (w_word),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  // Request FSM: latch on accept, count down latency, perform access, hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= OP_RD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.MemRead || bus.MemWrite) begin
            r_op    <= w_op_in;
            r_addr  <= bus.MemAddr;
            r_wdata <= bus.MemWriteData;
            r_cnt   <= CNT_INIT;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_err   <= w_bad;
            r_rdata <= (!w_bad && r_op == OP_RD) ? w_mem_rdata : 32'd0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.Resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Req_ready   = (r_state == IDLE);
  assign bus.Resp_valid  = (r_state == RESP);
  assign bus.MemReadData = r_rdata;
  assign bus.Mem_err     = r_err;

endmodule
